// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and oversampling tick positions.
// The transmitter uses the same state names.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  MID_TICK   = 4'd7;
  localparam logic [3:0]  LAST_TICK  = 4'(OVERSAMPLE - 1);

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    START  = 6'b000010,
    DATA   = 6'b000100,
    PARITY = 6'b001000,
    STOP   = 6'b010000,
    DONE   = 6'b100000
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      meta <= RESET_VAL;
      o_q  <= RESET_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first data, replicated parity bits, 1-2 stop bits.
// Delivers each frame with a one-cycle done pulse plus parity and framing flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STOP_WIDTH   = 1,
  parameter int unsigned PARITY_WIDTH = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_tick,
  input  logic                    i_rx,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [PARITY_WIDTH-1:0] o_parity,
  output logic                    o_parity_err,
  output logic                    o_frame_err,
  output logic                    o_done_bit,
  output logic                    o_busy
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_WIDTH - 1);
  localparam logic [2:0] LAST_PAR  = 3'(PARITY_WIDTH - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_WIDTH - 1);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  uart_state_t             state_q, state_d;
  logic [3:0]              tick_q, tick_d;
  logic [2:0]              idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [PARITY_WIDTH-1:0] par_q, par_d;
  logic                    stop_bad_q, stop_bad_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [PARITY_WIDTH-1:0] parity_q, parity_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic par_exp;
  logic par_bad;
  logic stop_hit;

  assign par_exp = (^shreg_q) ^ 1'(PARITY_ODD);

  always_comb begin
    par_bad = 1'b0;
    for (int unsigned i = 0; i < PARITY_WIDTH; i++) begin
      if (par_q[i] != par_exp) par_bad = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    stop_bad_d = stop_bad_q;
    data_d     = data_q;
    parity_d   = parity_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    stop_hit   = stop_bad_q | ~rx_s;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_q == MID_TICK) begin
            if (rx_s) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = DATA;
              tick_d  = '0;
              idx_d   = '0;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == LAST_TICK) begin
            shreg_d[idx_q] = rx_s;
            if (idx_q == LAST_DATA) begin
              state_d = PARITY;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end
      PARITY: begin
        if (i_tick) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == LAST_TICK) begin
            for (int unsigned i = 0; i < PARITY_WIDTH; i++) begin
              if (idx_q == 3'(i)) par_d[i] = rx_s;
            end
            if (idx_q == LAST_PAR) begin
              state_d    = STOP;
              idx_d      = '0;
              stop_bad_d = 1'b0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end
      STOP: begin
        // The last stop sample is folded in directly so results land together with done.
        if (i_tick) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == LAST_TICK) begin
            stop_bad_d = stop_hit;
            if (idx_q == LAST_STOP) begin
              state_d  = DONE;
              done_d   = 1'b1;
              busy_d   = 1'b0;
              data_d   = shreg_q;
              parity_d = par_q;
              perr_d   = par_bad;
              ferr_d   = stop_hit;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_q      <= '0;
      stop_bad_q <= 1'b0;
      data_q     <= '0;
      parity_q   <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      stop_bad_q <= stop_bad_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign o_data       = data_q;
  assign o_parity     = parity_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_done_bit   = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: default build (even, 1 parity, 1 stop) and an
// odd-parity build with 2 parity bits and 2 stop bits.
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] par;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx1 = 1'b1;
  logic       rx2 = 1'b1;
  logic [1:0] tcnt = '0;
  logic       tick;

  logic [7:0] data1, data2;
  logic       par1;
  logic [1:0] par2;
  logic       perr1, perr2, ferr1, ferr2, done1, done2, busy1, busy2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  // 16x baud tick every 4 clocks
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign tick = (tcnt == 2'd3);

  uart_rx dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_tick       (tick),
    .i_rx         (rx1),
    .o_data       (data1),
    .o_parity     (par1),
    .o_parity_err (perr1),
    .o_frame_err  (ferr1),
    .o_done_bit   (done1),
    .o_busy       (busy1)
  );

  uart_rx #(.STOP_WIDTH(2), .PARITY_WIDTH(2), .PARITY_ODD(1)) dut2 (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_tick       (tick),
    .i_rx         (rx2),
    .o_data       (data2),
    .o_parity     (par2),
    .o_parity_err (perr2),
    .o_frame_err  (ferr2),
    .o_done_bit   (done2),
    .o_busy       (busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per done pulse
  always @(negedge clk) begin
    if (done1) begin
      chk("dut1_done_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_data", 32'(data1), 32'(e.data));
        chk("dut1_parity", 32'(par1), 32'(e.par[0]));
        chk("dut1_parity_err", 32'(perr1), 32'(e.perr));
        chk("dut1_frame_err", 32'(ferr1), 32'(e.ferr));
      end
    end
    if (done2) begin
      chk("dut2_done_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_data", 32'(data2), 32'(e.data));
        chk("dut2_parity", 32'(par2), 32'(e.par));
        chk("dut2_parity_err", 32'(perr2), 32'(e.perr));
        chk("dut2_frame_err", 32'(ferr2), 32'(e.ferr));
      end
    end
  end

  // Must be entered right at a rising edge; returns at a rising edge
  task automatic drive(input int unsigned sel, input logic v, input int unsigned ticks);
    #1;
    if (sel == 0) rx1 = v;
    else          rx2 = v;
    repeat (ticks * 4) @(posedge clk);
  endtask

  task automatic send_frame(input int unsigned sel, input logic [7:0] d, input logic [1:0] p,
                            input logic stop_v, input int unsigned idle, input logic push,
                            input logic perr_e, input logic ferr_e);
    int unsigned nb = (sel == 0) ? 1 : 2;
    exp_t e;
    e.data = d;
    e.par  = (sel == 0) ? {1'b0, p[0]} : p;
    e.perr = perr_e;
    e.ferr = ferr_e;
    if (push) begin
      if (sel == 0) q1.push_back(e);
      else          q2.push_back(e);
    end
    drive(sel, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(sel, d[i], 16);
    for (int i = 0; i < int'(nb); i++) drive(sel, p[i], 16);
    for (int i = 0; i < int'(nb); i++) begin
      // A low stop bit is released after its mid sample so the tail cannot pass as a start bit
      if (i == 0) begin
        drive(sel, stop_v, 11);
        drive(sel, 1'b1, 5);
      end else begin
        drive(sel, 1'b1, 16);
      end
    end
    if (idle > 0) drive(sel, 1'b1, idle);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(data1), 32'd0);
    chk("reset_busy", 32'(busy1), 32'd0);
    chk("reset_done", 32'(done1), 32'd0);
    chk("reset_flags", 32'({perr1, ferr1, par1}), 32'd0);
    chk("reset_dut2", 32'({data2, par2, perr2, ferr2, busy2, done2}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    drive(0, 1'b1, 8);

    // 0xA5: 4 ones, even parity bit 0
    send_frame(0, 8'hA5, 2'b00, 1'b1, 16, 1'b1, 1'b0, 1'b0);
    // 0x01: 1 one, even parity bit should be 1, 0 sent
    send_frame(0, 8'h01, 2'b00, 1'b1, 16, 1'b1, 1'b1, 1'b0);
    // 0x3C with low stop bit, then clean 0x55
    send_frame(0, 8'h3C, 2'b00, 1'b0, 16, 1'b1, 1'b0, 1'b1);
    send_frame(0, 8'h55, 2'b00, 1'b1, 16, 1'b1, 1'b0, 1'b0);

    // Glitch: 4 ticks low then high
    drive(0, 1'b0, 2);
    chk("glitch_busy_high", 32'(busy1), 32'd1);
    drive(0, 1'b0, 2);
    drive(0, 1'b1, 12);
    chk("glitch_busy_low", 32'(busy1), 32'd0);
    chk("glitch_data_held", 32'(data1), 32'h55);
    drive(0, 1'b1, 8);

    // Reset in the middle of the data bits of 0xFF
    drive(0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 16);
    drive(0, 1'b1, 8);
    chk("pre_reset_busy", 32'(busy1), 32'd1);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_data", 32'(data1), 32'd0);
    chk("midreset_busy", 32'(busy1), 32'd0);
    chk("midreset_done", 32'(done1), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    drive(0, 1'b1, 40);
    chk("postreset_data", 32'(data1), 32'd0);
    send_frame(0, 8'h12, 2'b00, 1'b1, 16, 1'b1, 1'b0, 1'b0);

    // Back-to-back frames, start immediately after the stop bit
    send_frame(0, 8'h00, 2'b00, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'hFF, 2'b00, 1'b1, 16, 1'b1, 1'b0, 1'b0);

    // Odd parity, 2 parity bits, 2 stop bits
    drive(1, 1'b1, 4);
    send_frame(1, 8'hA5, 2'b10, 1'b1, 16, 1'b1, 1'b1, 1'b0);
    send_frame(1, 8'h00, 2'b11, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    send_frame(1, 8'hFF, 2'b11, 1'b1, 16, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 400 && (q1.size() != 0 || q2.size() != 0); i++) @(posedge clk);
    chk("dut1_all_frames_done", 32'(q1.size()), 32'd0);
    chk("dut2_all_frames_done", 32'(q2.size()), 32'd0);
    chk("final_data1", 32'(data1), 32'hFF);
    chk("final_data2", 32'(data2), 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
